// File: rtl/id_ex_stage.sv
// id_ex_stage: pipeline register between decode (ID) and execute (EX)
// of the 5-stage MIPS datapath.
//
// Purpose:
//   Captures the nine main-decoder control bits, the register-file
//   operands, the sign-extended immediate, PC+4 and the instruction
//   fields for the execute stage. It also contains the load-use hazard
//   detector, handles branch flush and holds its contents while the
//   downstream stage is not accepting.
//
// Ports:
//   Clk, Rst            clock, asynchronous active-high reset
//   ID_*                decode-side instruction, operands and control bits
//   Flush               squash the decode instruction (bubble into EX)
//   ExtStall            hold every EX register unchanged
//   HazardStall         combinational load-use stall for PC and IF/ID
//   EX_*                registered execute-side copies
//   EX_WriteReg         destination register (Rd if RegDst, else Rt)
//   BubbleCount         saturating count of inserted bubbles
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ID_Valid,
  input  logic [31:0]       ID_Instr,
  input  logic [DATA_W-1:0] ID_PCPlus4,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_SignExt,
  input  logic              ID_RegDst,
  input  logic              ID_ALUSrc,
  input  logic              ID_MemtoReg,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_Branch,
  input  logic              ID_ALUOp1,
  input  logic              ID_ALUOp0,
  input  logic              Flush,
  input  logic              ExtStall,
  output logic              HazardStall,
  output logic              EX_Valid,
  output logic              EX_RegDst,
  output logic              EX_ALUSrc,
  output logic              EX_MemtoReg,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_Branch,
  output logic              EX_ALUOp1,
  output logic              EX_ALUOp0,
  output logic [DATA_W-1:0] EX_PCPlus4,
  output logic [DATA_W-1:0] EX_ReadData1,
  output logic [DATA_W-1:0] EX_ReadData2,
  output logic [DATA_W-1:0] EX_SignExt,
  output logic [4:0]        EX_Rs,
  output logic [4:0]        EX_Rt,
  output logic [4:0]        EX_Rd,
  output logic [4:0]        EX_Shamt,
  output logic [5:0]        EX_Funct,
  output logic [5:0]        EX_Opcode,
  output logic [4:0]        EX_WriteReg,
  output logic [CNT_W-1:0]  BubbleCount
);

  // Control bits packed MSB-first in port order: RegDst .. ALUOp0.
  logic [8:0] id_ctrl;
  assign id_ctrl = {ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite, ID_MemRead,
                    ID_MemWrite, ID_Branch, ID_ALUOp1, ID_ALUOp0};

  logic              valid_q, valid_d;
  logic [8:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] pc_plus4_q, pc_plus4_d;
  logic [DATA_W-1:0] read_data1_q, read_data1_d;
  logic [DATA_W-1:0] read_data2_q, read_data2_d;
  logic [DATA_W-1:0] sign_ext_q, sign_ext_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
  logic [5:0]        funct_q, funct_d, opcode_q, opcode_d;
  logic [4:0]        write_reg_q, write_reg_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              hazard_stall;
  logic              insert_bubble;
  logic              count_bubble;

  // Load-use: the load in EX writes a register the decode instruction
  // reads. A load targeting $zero never stalls.
  always_comb begin
    hazard_stall = valid_q & ctrl_q[4] & (write_reg_q != 5'd0) & ID_Valid &
                   ((write_reg_q == ID_Instr[25:21]) | (write_reg_q == ID_Instr[20:16]));
  end
  assign HazardStall = hazard_stall;

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    pc_plus4_d   = pc_plus4_q;
    read_data1_d = read_data1_q;
    read_data2_d = read_data2_q;
    sign_ext_d   = sign_ext_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    shamt_d      = shamt_q;
    funct_d      = funct_q;
    opcode_d     = opcode_q;
    write_reg_d  = write_reg_q;
    bubble_cnt_d = bubble_cnt_q;

    // Flush overrides the hold; an empty decode slot also bubbles but is
    // not counted as an inserted bubble.
    count_bubble  = Flush | (~ExtStall & hazard_stall);
    insert_bubble = count_bubble | (~ExtStall & ~ID_Valid);

    if (insert_bubble) begin
      // Control forced to 0 so X from unused opcodes never reaches EX;
      // data fields simply hold.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!ExtStall) begin
      valid_d      = 1'b1;
      ctrl_d       = id_ctrl & {9{ID_Valid}};
      pc_plus4_d   = ID_PCPlus4;
      read_data1_d = ID_ReadData1;
      read_data2_d = ID_ReadData2;
      sign_ext_d   = ID_SignExt;
      rs_d         = ID_Instr[25:21];
      rt_d         = ID_Instr[20:16];
      rd_d         = ID_Instr[15:11];
      shamt_d      = ID_Instr[10:6];
      funct_d      = ID_Instr[5:0];
      opcode_d     = ID_Instr[31:26];
      write_reg_d  = ID_RegDst ? ID_Instr[15:11] : ID_Instr[20:16];
    end

    if (count_bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      pc_plus4_q   <= '0;
      read_data1_q <= '0;
      read_data2_q <= '0;
      sign_ext_q   <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      shamt_q      <= '0;
      funct_q      <= '0;
      opcode_q     <= '0;
      write_reg_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      pc_plus4_q   <= pc_plus4_d;
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
      sign_ext_q   <= sign_ext_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      shamt_q      <= shamt_d;
      funct_q      <= funct_d;
      opcode_q     <= opcode_d;
      write_reg_q  <= write_reg_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign EX_Valid     = valid_q;
  assign EX_RegDst    = ctrl_q[8];
  assign EX_ALUSrc    = ctrl_q[7];
  assign EX_MemtoReg  = ctrl_q[6];
  assign EX_RegWrite  = ctrl_q[5];
  assign EX_MemRead   = ctrl_q[4];
  assign EX_MemWrite  = ctrl_q[3];
  assign EX_Branch    = ctrl_q[2];
  assign EX_ALUOp1    = ctrl_q[1];
  assign EX_ALUOp0    = ctrl_q[0];
  assign EX_PCPlus4   = pc_plus4_q;
  assign EX_ReadData1 = read_data1_q;
  assign EX_ReadData2 = read_data2_q;
  assign EX_SignExt   = sign_ext_q;
  assign EX_Rs        = rs_q;
  assign EX_Rt        = rt_q;
  assign EX_Rd        = rd_q;
  assign EX_Shamt     = shamt_q;
  assign EX_Funct     = funct_q;
  assign EX_Opcode    = opcode_q;
  assign EX_WriteReg  = write_reg_q;
  assign BubbleCount  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: scoreboard of expected EX state pushed on
// every clocked step and popped/compared one cycle later.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [8:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [4:0]  wr;
    logic [15:0] bcnt;
  } ex_t;

  localparam logic [8:0]  CTRL_LW  = 9'h0F0; // ALUSrc MemtoReg RegWrite MemRead
  localparam logic [8:0]  CTRL_ADD = 9'h122; // RegDst RegWrite ALUOp1
  localparam logic [31:0] I_ADD3   = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] I_LW5    = 32'h8C850000; // lw  $5,0($4)
  localparam logic [31:0] I_ADD6   = 32'h00A73020; // add $6,$5,$7
  localparam logic [31:0] I_LW0    = 32'h8C800000; // lw  $0,0($4)
  localparam logic [31:0] I_ADD6Z  = 32'h00073020; // add $6,$0,$7
  localparam logic [31:0] I_ADD8   = 32'h00C74020; // add $8,$6,$7

  logic        Clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_rd1, id_rd2, id_sext;
  logic [8:0]  id_ctrl;
  logic        flush, ext_stall;
  logic        hazard_stall, ex_valid;
  logic        ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread;
  logic        ex_memwrite, ex_branch, ex_aluop1, ex_aluop0;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_sext;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt, ex_wr;
  logic [5:0]  ex_funct, ex_opcode;
  logic [15:0] bubble_count;

  int   errors = 0;
  int   checks = 0;
  ex_t  sb[$];
  ex_t  m;
  ex_t  exp_s, obs_s, saved;

  always #5 Clk = ~Clk;

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(rst), .ID_Valid(id_valid), .ID_Instr(id_instr),
    .ID_PCPlus4(id_pc), .ID_ReadData1(id_rd1), .ID_ReadData2(id_rd2),
    .ID_SignExt(id_sext),
    .ID_RegDst(id_ctrl[8]), .ID_ALUSrc(id_ctrl[7]), .ID_MemtoReg(id_ctrl[6]),
    .ID_RegWrite(id_ctrl[5]), .ID_MemRead(id_ctrl[4]), .ID_MemWrite(id_ctrl[3]),
    .ID_Branch(id_ctrl[2]), .ID_ALUOp1(id_ctrl[1]), .ID_ALUOp0(id_ctrl[0]),
    .Flush(flush), .ExtStall(ext_stall), .HazardStall(hazard_stall),
    .EX_Valid(ex_valid),
    .EX_RegDst(ex_regdst), .EX_ALUSrc(ex_alusrc), .EX_MemtoReg(ex_memtoreg),
    .EX_RegWrite(ex_regwrite), .EX_MemRead(ex_memread), .EX_MemWrite(ex_memwrite),
    .EX_Branch(ex_branch), .EX_ALUOp1(ex_aluop1), .EX_ALUOp0(ex_aluop0),
    .EX_PCPlus4(ex_pc), .EX_ReadData1(ex_rd1), .EX_ReadData2(ex_rd2),
    .EX_SignExt(ex_sext), .EX_Rs(ex_rs), .EX_Rt(ex_rt), .EX_Rd(ex_rd),
    .EX_Shamt(ex_shamt), .EX_Funct(ex_funct), .EX_Opcode(ex_opcode),
    .EX_WriteReg(ex_wr), .BubbleCount(bubble_count)
  );

  function automatic ex_t sample();
    ex_t s;
    s.valid = ex_valid;
    s.ctrl  = {ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
               ex_memwrite, ex_branch, ex_aluop1, ex_aluop0};
    s.pc = ex_pc; s.rd1 = ex_rd1; s.rd2 = ex_rd2; s.sext = ex_sext;
    s.rs = ex_rs; s.rt = ex_rt; s.rd = ex_rd; s.shamt = ex_shamt;
    s.funct = ex_funct; s.opcode = ex_opcode; s.wr = ex_wr;
    s.bcnt = bubble_count;
    return s;
  endfunction

  function automatic logic model_hz(ex_t c);
    return c.valid & c.ctrl[4] & (c.wr != 5'd0) & id_valid &
           ((c.wr == id_instr[25:21]) | (c.wr == id_instr[20:16]));
  endfunction

  function automatic ex_t next_model(ex_t c);
    ex_t n;
    n = c;
    if (flush) begin
      n.valid = 1'b0; n.ctrl = '0;
      if (n.bcnt != 16'hFFFF) n.bcnt = n.bcnt + 16'd1;
    end else if (ext_stall) begin
      n = c;
    end else if (model_hz(c)) begin
      n.valid = 1'b0; n.ctrl = '0;
      if (n.bcnt != 16'hFFFF) n.bcnt = n.bcnt + 16'd1;
    end else if (!id_valid) begin
      n.valid = 1'b0; n.ctrl = '0;
    end else begin
      n.valid = 1'b1; n.ctrl = id_ctrl;
      n.pc = id_pc; n.rd1 = id_rd1; n.rd2 = id_rd2; n.sext = id_sext;
      n.rs = id_instr[25:21]; n.rt = id_instr[20:16]; n.rd = id_instr[15:11];
      n.shamt = id_instr[10:6]; n.funct = id_instr[5:0]; n.opcode = id_instr[31:26];
      n.wr = id_ctrl[8] ? id_instr[15:11] : id_instr[20:16];
    end
    return n;
  endfunction

  // One clock: push the expected EX state, advance, sample 1 time unit later.
  task automatic cycle();
    ex_t n;
    n = next_model(m);
    sb.push_back(n);
    m = n;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] instr, input logic [8:0] ctrl);
    id_valid = v;
    id_instr = instr;
    id_ctrl  = ctrl;
    id_pc    = $urandom;
    id_rd1   = $urandom;
    id_rd2   = $urandom;
    id_sext  = $urandom;
  endtask

  task automatic test_reset();
    #2;
    obs_s = sample();
    checks++;
    if (obs_s !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0", obs_s);
    end
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_hazard got=%b want=0", hazard_stall);
    end
    rst = 1'b0;
    m = '0;
    $display("reset: EX state=%h", obs_s);
  endtask

  task automatic test_plain_load();
    set_id(1'b1, I_ADD3, CTRL_ADD);
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s) begin
      errors++;
      $display("FAIL plain_load state got=%h want=%h", obs_s, exp_s);
    end
    checks++;
    if ({ex_valid, ex_rd, ex_wr, ex_funct, ex_regwrite, ex_aluop1} !==
        {1'b1, 5'd3, 5'd3, 6'h20, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL plain_load fields got v=%b rd=%0d wr=%0d funct=%h want v=1 rd=3 wr=3 funct=20",
               ex_valid, ex_rd, ex_wr, ex_funct);
    end
    $display("plain_load: rd=%0d wr=%0d funct=%h", ex_rd, ex_wr, ex_funct);
  endtask

  task automatic test_load_use();
    logic [15:0] b0;
    set_id(1'b0, '0, '0);
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL load_use empty got=%h want=%h", obs_s, exp_s); end
    set_id(1'b1, I_LW5, CTRL_LW);
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL load_use lw got=%h want=%h", obs_s, exp_s); end
    b0 = bubble_count;
    set_id(1'b1, I_ADD6, CTRL_ADD);
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin errors++; $display("FAIL load_use hazard got=%b want=1", hazard_stall); end
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL load_use bubble got=%h want=%h", obs_s, exp_s); end
    checks++;
    if ({ex_valid, ex_regwrite, bubble_count} !== {1'b0, 1'b0, b0 + 16'd1}) begin
      errors++;
      $display("FAIL load_use bubble_fields got v=%b rw=%b cnt=%0d want v=0 rw=0 cnt=%0d",
               ex_valid, ex_regwrite, bubble_count, b0 + 16'd1);
    end
    checks++;
    if (hazard_stall !== 1'b0) begin errors++; $display("FAIL load_use hazard_drop got=%b want=0", hazard_stall); end
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s || ex_rd !== 5'd6 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_use add got=%h want=%h", obs_s, exp_s);
    end
    $display("load_use: bubbles=%0d rd=%0d", bubble_count, ex_rd);
  endtask

  task automatic test_no_false_stall();
    set_id(1'b1, I_LW0, CTRL_LW);
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL nostall lw0 got=%h want=%h", obs_s, exp_s); end
    set_id(1'b1, I_ADD6Z, CTRL_ADD);
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin errors++; $display("FAIL nostall zero_reg got=%b want=0", hazard_stall); end
    set_id(1'b1, I_LW5, CTRL_LW);
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL nostall lw5 got=%h want=%h", obs_s, exp_s); end
    set_id(1'b1, I_ADD8, CTRL_ADD);
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin errors++; $display("FAIL nostall other_regs got=%b want=0", hazard_stall); end
    // Empty decode slot with garbage control bits: nothing may leak into EX.
    set_id(1'b0, I_ADD8, 9'h1FF);
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s || obs_s.ctrl !== 9'h000) begin
      errors++;
      $display("FAIL nostall empty_slot got=%h want=%h", obs_s, exp_s);
    end
    $display("no_false_stall: hazard=%b ctrl=%h", hazard_stall, obs_s.ctrl);
  endtask

  task automatic test_flush_ext_stall();
    logic [15:0] b0;
    set_id(1'b1, I_ADD3, CTRL_ADD);
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL flush_ext load got=%h want=%h", obs_s, exp_s); end
    b0 = bubble_count;
    set_id(1'b1, I_ADD8, 9'h1FF);
    flush = 1'b1; ext_stall = 1'b1;
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s || obs_s.valid !== 1'b0 || obs_s.ctrl !== 9'h000 || obs_s.bcnt !== b0 + 16'd1) begin
      errors++;
      $display("FAIL flush_ext both got=%h want=%h", obs_s, exp_s);
    end
    flush = 1'b0; ext_stall = 1'b0;
    set_id(1'b1, I_LW5, CTRL_LW);
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL flush_ext reload got=%h want=%h", obs_s, exp_s); end
    saved = obs_s;
    ext_stall = 1'b1;
    set_id(1'b1, I_ADD6, CTRL_ADD); // would hazard, but hold wins
    for (int i = 0; i < 3; i++) begin
      cycle();
      exp_s = sb.pop_front(); obs_s = sample();
      checks++;
      if (obs_s !== exp_s || obs_s !== saved) begin
        errors++;
        $display("FAIL flush_ext hold%0d got=%h want=%h", i, obs_s, saved);
      end
    end
    ext_stall = 1'b0;
    $display("flush_ext_stall: bubbles=%0d held=%h", bubble_count, obs_s);
  endtask

  task automatic test_back_to_back();
    logic [31:0] instr;
    for (int i = 0; i < 300; i++) begin
      instr = $urandom;
      instr[25:21] = 5'($urandom_range(0, 7));
      instr[20:16] = 5'($urandom_range(0, 7));
      instr[15:11] = 5'($urandom_range(0, 7));
      set_id(($urandom % 4) != 0, instr, 9'($urandom));
      flush     = ($urandom % 8) == 0;
      ext_stall = ($urandom % 5) == 0;
      #1;
      checks++;
      if (hazard_stall !== model_hz(m)) begin
        errors++;
        $display("FAIL b2b hazard%0d got=%b want=%b", i, hazard_stall, model_hz(m));
      end
      cycle();
      exp_s = sb.pop_front(); obs_s = sample();
      checks++;
      if (obs_s !== exp_s) begin
        errors++;
        $display("FAIL b2b state%0d got=%h want=%h", i, obs_s, exp_s);
      end
    end
    flush = 1'b0; ext_stall = 1'b0;
    $display("back_to_back: bubbles=%0d", bubble_count);
  endtask

  task automatic test_reset_midrun();
    set_id(1'b0, '0, '0);
    flush = 1'b1;
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL rst_mid flush got=%h want=%h", obs_s, exp_s); end
    flush = 1'b0;
    set_id(1'b1, I_LW5, CTRL_LW);
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid load got=%h want=%h", obs_s, exp_s);
    end
    set_id(1'b1, I_ADD6, CTRL_ADD);
    #2;
    rst = 1'b1;
    #1;
    obs_s = sample();
    checks++;
    if (obs_s !== '0) begin errors++; $display("FAIL rst_mid state got=%h want=0", obs_s); end
    checks++;
    if (hazard_stall !== 1'b0) begin errors++; $display("FAIL rst_mid hazard got=%b want=0", hazard_stall); end
    #1;
    rst = 1'b0;
    m = '0;
    $display("reset_midrun: EX state=%h", obs_s);
  endtask

  task automatic test_saturation();
    flush = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      set_id(1'b1, I_ADD3, 9'($urandom));
      cycle();
      exp_s = sb.pop_front(); obs_s = sample();
      checks++;
      if (obs_s !== exp_s) begin
        errors++;
        $display("FAIL sat step%0d got=%h want=%h", i, obs_s, exp_s);
      end
    end
    flush = 1'b0;
    checks++;
    if (bubble_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat flush_count got=%h want=ffff", bubble_count);
    end
    // One more bubble via the hazard path must also leave the count pinned.
    set_id(1'b1, I_LW5, CTRL_LW);
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL sat lw got=%h want=%h", obs_s, exp_s); end
    set_id(1'b1, I_ADD6, CTRL_ADD);
    cycle();
    exp_s = sb.pop_front(); obs_s = sample();
    checks++;
    if (obs_s !== exp_s || bubble_count !== 16'hFFFF || ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat hazard_count got=%h want=ffff", bubble_count);
    end
    $display("saturation: BubbleCount=%h", bubble_count);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ext_stall = 1'b0;
    set_id(1'b0, '0, '0);
    m = '0;
    test_reset();
    test_plain_load();
    test_load_use();
    test_no_false_stall();
    test_flush_ext_stall();
    test_back_to_back();
    test_reset_midrun();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
